// File: rtl/alu_control_pipe.sv
// Registered ALU control decoder for the ID/EX boundary, with a latency
// sequencer that stalls the pipeline while a MULT or DIV occupies EX.
module alu_control_pipe #(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 8,
    parameter bit          MC_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       stall,
    input  logic       flush,
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic       out_valid,
    output logic [3:0] alu_ctrl,
    output logic       illegal,
    output logic       mc_busy,
    output logic       stall_req,
    output logic       mc_done
);

    localparam logic [3:0] CTRL_MULT   = 4'b0101;
    localparam logic [3:0] CTRL_DIV    = 4'b1011;
    localparam logic [7:0] MULT_CNT    = 8'(MULT_LAT - 1);
    localparam logic [7:0] DIV_CNT     = 8'(DIV_LAT - 1);
    localparam bit         MULT_SINGLE = (MULT_LAT <= 1);
    localparam bit         DIV_SINGLE  = (DIV_LAT <= 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       out_valid_reg, out_valid_next;
    logic [3:0] alu_ctrl_reg, alu_ctrl_next;
    logic       illegal_reg, illegal_next;
    logic       mc_done_reg, mc_done_next;

    logic [3:0] dec_ctrl;
    logic       dec_undef;
    logic       mc_start;
    logic       mc_is_div;

    always_comb begin
        dec_ctrl  = 4'b0000;
        dec_undef = 1'b0;
        case (alu_op)
            2'b00: dec_ctrl = 4'b0010;
            2'b01: dec_ctrl = 4'b0110;
            2'b11: dec_ctrl = 4'b0000;
            default: begin
                case (funct)
                    6'b100100: dec_ctrl = 4'b0000;
                    6'b100101: dec_ctrl = 4'b0001;
                    6'b100000: dec_ctrl = 4'b0010;
                    6'b100010: dec_ctrl = 4'b0110;
                    6'b100110: dec_ctrl = 4'b0100;
                    6'b011000: dec_ctrl = CTRL_MULT;
                    6'b101010: dec_ctrl = 4'b0111;
                    6'b000000: dec_ctrl = 4'b1000;
                    6'b000010: dec_ctrl = 4'b1001;
                    6'b000011: dec_ctrl = 4'b1010;
                    6'b011010: dec_ctrl = CTRL_DIV;
                    6'b100111: dec_ctrl = 4'b1100;
                    default:   dec_undef = 1'b1;
                endcase
            end
        endcase
    end

    // Only the ALUOp=10 table can produce the MULT/DIV codes, so the code alone
    // identifies a multi-cycle op; undefined functs decode to 0000 and never start.
    assign mc_is_div = (dec_ctrl == CTRL_DIV);
    assign mc_start  = in_valid && MC_EN && !dec_undef &&
                       ((dec_ctrl == CTRL_MULT) || mc_is_div);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        out_valid_next = out_valid_reg;
        alu_ctrl_next  = alu_ctrl_reg;
        illegal_next   = illegal_reg;
        mc_done_next   = 1'b0;
        if (flush) begin
            state_next     = IDLE;
            cnt_next       = 8'd0;
            out_valid_next = 1'b0;
            alu_ctrl_next  = 4'b0000;
            illegal_next   = 1'b0;
        end else if (state_reg == BUSY) begin
            // Counter keeps running regardless of the stall input.
            cnt_next = cnt_reg - 8'd1;
            if (cnt_reg == 8'd1) begin
                state_next   = IDLE;
                mc_done_next = 1'b1;
            end
        end else if (!stall) begin
            out_valid_next = in_valid;
            alu_ctrl_next  = in_valid ? dec_ctrl : 4'b0000;
            illegal_next   = in_valid & dec_undef;
            if (mc_start) begin
                if (mc_is_div ? DIV_SINGLE : MULT_SINGLE) begin
                    mc_done_next = 1'b1;
                end else begin
                    state_next = BUSY;
                    cnt_next   = mc_is_div ? DIV_CNT : MULT_CNT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 8'd0;
            out_valid_reg <= 1'b0;
            alu_ctrl_reg  <= 4'b0000;
            illegal_reg   <= 1'b0;
            mc_done_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= out_valid_next;
            alu_ctrl_reg  <= alu_ctrl_next;
            illegal_reg   <= illegal_next;
            mc_done_reg   <= mc_done_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign alu_ctrl  = alu_ctrl_reg;
    assign illegal   = illegal_reg;
    assign mc_done   = mc_done_reg;
    assign mc_busy   = (state_reg == BUSY);
    assign stall_req = mc_busy;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Scoreboard bench for alu_control_pipe: default, MC_EN=0 and latency-1/2 instances
// share one stimulus; observed word is {out_valid, alu_ctrl, illegal, mc_busy, stall_req, mc_done}.
module tb_alu_control_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [1:0] alu_op = 2'b00;
    logic [5:0] funct = 6'b000000;

    logic       ov_a, ill_a, busy_a, sreq_a, done_a;
    logic [3:0] ctrl_a;
    logic       ov_n, ill_n, busy_n, sreq_n, done_n;
    logic [3:0] ctrl_n;
    logic       ov_1, ill_1, busy_1, sreq_1, done_1;
    logic [3:0] ctrl_1;

    logic [8:0] obs_a, obs_n, obs_1;
    assign obs_a = {ov_a, ctrl_a, ill_a, busy_a, sreq_a, done_a};
    assign obs_n = {ov_n, ctrl_n, ill_n, busy_n, sreq_n, done_n};
    assign obs_1 = {ov_1, ctrl_1, ill_1, busy_1, sreq_1, done_1};

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] sb[$];
    logic [8:0] exp_w;

    always #5 clk = ~clk;

    alu_control_pipe #(.MULT_LAT(4), .DIV_LAT(8), .MC_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_op(alu_op), .funct(funct), .out_valid(ov_a), .alu_ctrl(ctrl_a),
        .illegal(ill_a), .mc_busy(busy_a), .stall_req(sreq_a), .mc_done(done_a));

    alu_control_pipe #(.MULT_LAT(4), .DIV_LAT(8), .MC_EN(1'b0)) dut_nomc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_op(alu_op), .funct(funct), .out_valid(ov_n), .alu_ctrl(ctrl_n),
        .illegal(ill_n), .mc_busy(busy_n), .stall_req(sreq_n), .mc_done(done_n));

    alu_control_pipe #(.MULT_LAT(1), .DIV_LAT(2), .MC_EN(1'b1)) dut_lat1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_op(alu_op), .funct(funct), .out_valid(ov_1), .alu_ctrl(ctrl_1),
        .illegal(ill_1), .mc_busy(busy_1), .stall_req(sreq_1), .mc_done(done_1));

    function automatic logic [8:0] exp_word(input logic v, input logic [3:0] c,
                                            input logic il, input logic busy, input logic done);
        return {v, c, il, busy, busy, done};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f);
        in_valid = v;
        alu_op   = op;
        funct    = f;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'b00, 6'b000000);
        stall = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_a !== 9'd0) begin n_fail++; $display("FAIL reset_a got=%b want=%b", obs_a, 9'd0); end
        else $display("ok   reset_a got=%b", obs_a);
        n_checks++;
        if (obs_n !== 9'd0) begin n_fail++; $display("FAIL reset_nomc got=%b want=%b", obs_n, 9'd0); end
        else $display("ok   reset_nomc got=%b", obs_n);
        n_checks++;
        if (obs_1 !== 9'd0) begin n_fail++; $display("FAIL reset_lat1 got=%b want=%b", obs_1, 9'd0); end
        else $display("ok   reset_lat1 got=%b", obs_1);
        do_reset();
    endtask

    task automatic test_stream();
        logic [1:0] ops[7] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b11};
        logic [5:0] fs[7]  = '{6'b100000, 6'b100010, 6'b100111, 6'b000000, 6'b000000, 6'b000000, 6'b111111};
        logic [3:0] cs[7]  = '{4'b0010, 4'b0110, 4'b1100, 4'b0010, 4'b0110, 4'b0000, 4'b0000};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ops[i], fs[i]);
            sb.push_back(exp_word(1'b1, cs[i], 1'b0, 1'b0, 1'b0));
            step();
            exp_w = sb.pop_front();
            n_checks++;
            if (obs_a !== exp_w) begin n_fail++; $display("FAIL stream[%0d] got=%b want=%b", i, obs_a, exp_w); end
            else $display("ok   stream[%0d] got=%b", i, obs_a);
        end
        drive(1'b0, 2'b10, 6'b011000);
        sb.push_back(exp_word(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0));
        step();
        exp_w = sb.pop_front();
        n_checks++;
        if (obs_a !== exp_w) begin n_fail++; $display("FAIL bubble got=%b want=%b", obs_a, exp_w); end
        else $display("ok   bubble got=%b", obs_a);
    endtask

    task automatic test_funct_table();
        logic [5:0] fs[14] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b100110, 6'b011000, 6'b101010,
                               6'b000000, 6'b000010, 6'b000011, 6'b011010, 6'b100111, 6'b111111, 6'b100001};
        logic [3:0] cs[14] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'h0, 4'h0};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 2'b10, fs[i]);
            sb.push_back(exp_word(1'b1, cs[i], (i >= 12), 1'b0, 1'b0));
            step();
            exp_w = sb.pop_front();
            n_checks++;
            if (obs_n !== exp_w) begin n_fail++; $display("FAIL funct[%0d] got=%b want=%b", i, obs_n, exp_w); end
            else $display("ok   funct[%0d] got=%b", i, obs_n);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(1'b1, 2'b10, 6'b111111);
        sb.push_back(exp_word(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0));
        step();
        drive(1'b0, 2'b00, 6'b000000);
        sb.push_back(exp_word(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++) begin
            exp_w = sb.pop_front();
            n_checks++;
            if (obs_a !== exp_w) begin n_fail++; $display("FAIL illegal[%0d] got=%b want=%b", i, obs_a, exp_w); end
            else $display("ok   illegal[%0d] got=%b", i, obs_a);
            if (i == 0) step();
        end
    endtask

    task automatic run_mc(input logic [5:0] f, input logic [3:0] code, input int lat, input logic hold);
        do_reset();
        drive(1'b1, 2'b10, f);
        for (int k = 1; k <= lat; k++) begin
            sb.push_back(exp_word(1'b1, code, 1'b0, (k < lat), (k == lat)));
            step();
            if (k == 1) begin
                drive(1'b1, 2'b10, 6'b100000);
                stall = hold;
            end
            exp_w = sb.pop_front();
            n_checks++;
            if (obs_a !== exp_w) begin n_fail++; $display("FAIL mc_%h cyc%0d got=%b want=%b", code, k, obs_a, exp_w); end
            else $display("ok   mc_%h cyc%0d got=%b", code, k, obs_a);
        end
        // With stall held the register keeps the op and mc_done must not repeat.
        if (hold) sb.push_back(exp_word(1'b1, code, 1'b0, 1'b0, 1'b0));
        else      sb.push_back(exp_word(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0));
        step();
        exp_w = sb.pop_front();
        n_checks++;
        if (obs_a !== exp_w) begin n_fail++; $display("FAIL mc_%h after got=%b want=%b", code, obs_a, exp_w); end
        else $display("ok   mc_%h after got=%b", code, obs_a);
        stall = 1'b0;
    endtask

    task automatic test_multicycle();
        run_mc(6'b011000, 4'b0101, 4, 1'b0);
        run_mc(6'b011010, 4'b1011, 8, 1'b0);
        run_mc(6'b011000, 4'b0101, 4, 1'b1);
    endtask

    task automatic test_flush_busy();
        do_reset();
        drive(1'b1, 2'b10, 6'b011010);
        for (int k = 1; k <= 3; k++) begin
            step();
            drive(1'b0, 2'b00, 6'b000000);
            if (k == 3) flush = 1'b1;
            exp_w = exp_word(1'b1, 4'b1011, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (obs_a !== exp_w) begin n_fail++; $display("FAIL flushbusy cyc%0d got=%b want=%b", k, obs_a, exp_w); end
            else $display("ok   flushbusy cyc%0d got=%b", k, obs_a);
        end
        step();
        flush = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (obs_a !== 9'd0) begin n_fail++; $display("FAIL flushed[%0d] got=%b want=%b", k, obs_a, 9'd0); end
            else $display("ok   flushed[%0d] got=%b", k, obs_a);
            step();
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(1'b1, 2'b10, 6'b100000);
        sb.push_back(exp_word(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0));
        step();
        stall = 1'b1;
        drive(1'b1, 2'b10, 6'b100010);
        sb.push_back(exp_word(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0));
        sb.push_back(exp_word(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0));
        sb.push_back(exp_word(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0));
        sb.push_back(exp_word(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            exp_w = sb.pop_front();
            n_checks++;
            if (obs_a !== exp_w) begin n_fail++; $display("FAIL stall[%0d] got=%b want=%b", i, obs_a, exp_w); end
            else $display("ok   stall[%0d] got=%b", i, obs_a);
            if (i == 2) stall = 1'b0;
            if (i == 3) begin stall = 1'b1; flush = 1'b1; end
            if (i < 4) step();
        end
        stall = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_mc_en0();
        logic [5:0] fs[2] = '{6'b011000, 6'b011010};
        logic [3:0] cs[2] = '{4'b0101, 4'b1011};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'b10, fs[i]);
            sb.push_back(exp_word(1'b1, cs[i], 1'b0, 1'b0, 1'b0));
            step();
            exp_w = sb.pop_front();
            n_checks++;
            if (obs_n !== exp_w) begin n_fail++; $display("FAIL mcen0[%0d] got=%b want=%b", i, obs_n, exp_w); end
            else $display("ok   mcen0[%0d] got=%b", i, obs_n);
        end
    endtask

    task automatic test_lat1();
        logic [5:0] fs[5] = '{6'b011000, 6'b100000, 6'b011010, 6'b100010, 6'b100010};
        logic [8:0] ex[5];
        ex[0] = exp_word(1'b1, 4'b0101, 1'b0, 1'b0, 1'b1);
        ex[1] = exp_word(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
        ex[2] = exp_word(1'b1, 4'b1011, 1'b0, 1'b1, 1'b0);
        ex[3] = exp_word(1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
        ex[4] = exp_word(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b10, fs[i]);
            sb.push_back(ex[i]);
            step();
            exp_w = sb.pop_front();
            n_checks++;
            if (obs_1 !== exp_w) begin n_fail++; $display("FAIL lat1[%0d] got=%b want=%b", i, obs_1, exp_w); end
            else $display("ok   lat1[%0d] got=%b", i, obs_1);
        end
    endtask

    task automatic test_reset_busy();
        do_reset();
        drive(1'b1, 2'b10, 6'b011000);
        step();
        drive(1'b0, 2'b00, 6'b000000);
        exp_w = exp_word(1'b1, 4'b0101, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (obs_a !== exp_w) begin n_fail++; $display("FAIL rstbusy_pre got=%b want=%b", obs_a, exp_w); end
        else $display("ok   rstbusy_pre got=%b", obs_a);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_a !== 9'd0) begin n_fail++; $display("FAIL rstbusy_async got=%b want=%b", obs_a, 9'd0); end
        else $display("ok   rstbusy_async got=%b", obs_a);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (obs_a !== 9'd0) begin n_fail++; $display("FAIL rstbusy_after[%0d] got=%b want=%b", k, obs_a, 9'd0); end
            else $display("ok   rstbusy_after[%0d] got=%b", k, obs_a);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_funct_table();
        test_illegal();
        test_multicycle();
        test_flush_busy();
        test_stall_flush();
        test_mc_en0();
        test_lat1();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
